// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter that shares one AHB-Lite master port among N requesters.
// It runs one single transfer at a time: an address phase (NONSEQ/SINGLE), then a data phase.
module ahb_master_arbiter #(
  parameter int N  = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N-1:0]    req_write,
  input  logic [N*DW-1:0] req_wdata,
  input  logic [N*3-1:0]  req_size,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    done,
  output logic [DW-1:0]   rsp_rdata,
  output logic            rsp_err,
  output logic            HSEL,
  output logic [AW-1:0]   HADDR,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic [DW-1:0]   HWDATA,
  output logic            HREADY,
  input  logic [DW-1:0]   HRDATA,
  input  logic            HREADYOUT,
  input  logic            HRESP
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   cur;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [DW-1:0]   lat_wdata;
  int              idx;

  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;
  assign HREADY = HREADYOUT;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    ack = '0;
    if (state == IDLE && gnt_any) ack[gnt_idx] = 1'b1;
  end

  // Write data is only consumed after the grant, so it needs no reset.
  always_ff @(posedge HCLK) begin
    if (state == IDLE && gnt_any) lat_wdata <= req_wdata[int'(gnt_idx)*DW +: DW];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      last      <= IW'(N-1);
      cur       <= '0;
      HTRANS    <= 2'b00;
      HSEL      <= 1'b0;
      HADDR     <= '0;
      HWDATA    <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= 3'b000;
      done      <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            cur    <= gnt_idx;
            last   <= gnt_idx;
            HADDR  <= req_addr[int'(gnt_idx)*AW +: AW];
            HWRITE <= req_write[gnt_idx];
            HSIZE  <= req_size[int'(gnt_idx)*3 +: 3];
            HTRANS <= 2'b10;
            HSEL   <= 1'b1;
            state  <= ADDR;
          end
        end
        ADDR: begin
          if (HREADYOUT) begin
            HTRANS <= 2'b00;
            HSEL   <= 1'b0;
            if (HWRITE) HWDATA <= lat_wdata;
            state  <= DATA;
          end
        end
        DATA: begin
          // A two-cycle error response completes on its second (HREADYOUT=1) cycle.
          if (HREADYOUT) begin
            done[cur] <= 1'b1;
            rsp_err   <= HRESP;
            if (!HWRITE) rsp_rdata <= HRDATA;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter (N=4): per-cycle vector table plus
// hand-written round-robin and mid-transfer reset sequences.
module tb_ahb_master_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            HCLK;
  logic            HRESET;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_write;
  logic [N*DW-1:0] req_wdata;
  logic [N*3-1:0]  req_size;
  logic [N-1:0]    ack;
  logic [N-1:0]    done;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            HSEL;
  logic [AW-1:0]   HADDR;
  logic            HWRITE;
  logic [2:0]      HSIZE;
  logic [2:0]      HBURST;
  logic [3:0]      HPROT;
  logic [1:0]      HTRANS;
  logic [DW-1:0]   HWDATA;
  logic            HREADY;
  logic [DW-1:0]   HRDATA;
  logic            HREADYOUT;
  logic            HRESP;

  ahb_master_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req(req), .req_addr(req_addr), .req_write(req_write),
    .req_wdata(req_wdata), .req_size(req_size),
    .ack(ack), .done(done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int checks;
  int errors;

  typedef struct {
    logic [3:0]  rq;
    logic        rdy;
    logic        resp;
    logic [31:0] rdata;
    logic [3:0]  e_ack;
    logic [1:0]  e_trans;
    logic        e_sel;
    logic        e_write;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_done;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(logic [3:0] rq, logic rdy, logic resp, logic [31:0] rdata,
                              logic [3:0] e_ack, logic [1:0] e_trans, logic e_sel,
                              logic e_write, logic [31:0] e_addr, logic [31:0] e_wdata,
                              logic [3:0] e_done, logic e_err, logic [31:0] e_rdata);
    vec_t v;
    v.rq = rq; v.rdy = rdy; v.resp = resp; v.rdata = rdata;
    v.e_ack = e_ack; v.e_trans = e_trans; v.e_sel = e_sel; v.e_write = e_write;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_done = e_done;
    v.e_err = e_err; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rq, input logic rdy, input logic resp,
                       input logic [31:0] rdata);
    @(posedge HCLK);
    #1;
    req = rq; HREADYOUT = rdy; HRESP = resp; HRDATA = rdata;
    @(negedge HCLK);
  endtask

  int order [5];
  logic [3:0] exp_ack;
  logic [3:0] exp_done;

  initial begin
    checks = 0;
    errors = 0;
    HRESET = 1'b1;
    req = '0; HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = 32'h100 + 32'(i) * 32'h10;
      req_wdata[i*DW +: DW] = 32'hA5A5_0001 + 32'(i);
      req_size[i*3 +: 3]    = 3'b010;
    end
    req_write = 4'b0101;

    // Rows: req rdy resp hrdata | ack trans sel write addr wdata done err rdata
    tbl[0]  = mk(4'h1,1,0,32'h0,        4'h1,2'd0,0,0,32'h000,32'h0,        4'h0,0,32'h0);
    tbl[1]  = mk(4'h0,1,0,32'h0,        4'h0,2'd2,1,1,32'h100,32'h0,        4'h0,0,32'h0);
    tbl[2]  = mk(4'h0,1,0,32'h0,        4'h0,2'd0,0,1,32'h100,32'hA5A50001, 4'h0,0,32'h0);
    tbl[3]  = mk(4'h0,1,0,32'h0,        4'h0,2'd0,0,1,32'h100,32'hA5A50001, 4'h1,0,32'h0);
    tbl[4]  = mk(4'h2,1,0,32'h0,        4'h2,2'd0,0,1,32'h100,32'hA5A50001, 4'h0,0,32'h0);
    tbl[5]  = mk(4'h0,1,0,32'h0,        4'h0,2'd2,1,0,32'h110,32'hA5A50001, 4'h0,0,32'h0);
    tbl[6]  = mk(4'h0,0,0,32'h0,        4'h0,2'd0,0,0,32'h110,32'hA5A50001, 4'h0,0,32'h0);
    tbl[7]  = mk(4'h0,0,0,32'h0,        4'h0,2'd0,0,0,32'h110,32'hA5A50001, 4'h0,0,32'h0);
    tbl[8]  = mk(4'h0,1,0,32'hDEADBEEF, 4'h0,2'd0,0,0,32'h110,32'hA5A50001, 4'h0,0,32'h0);
    tbl[9]  = mk(4'h0,1,0,32'h0,        4'h0,2'd0,0,0,32'h110,32'hA5A50001, 4'h2,0,32'hDEADBEEF);
    tbl[10] = mk(4'h4,1,0,32'h0,        4'h4,2'd0,0,0,32'h110,32'hA5A50001, 4'h0,0,32'hDEADBEEF);
    tbl[11] = mk(4'h0,1,0,32'h0,        4'h0,2'd2,1,1,32'h120,32'hA5A50001, 4'h0,0,32'hDEADBEEF);
    tbl[12] = mk(4'h0,0,1,32'h12345678, 4'h0,2'd0,0,1,32'h120,32'hA5A50003, 4'h0,0,32'hDEADBEEF);
    tbl[13] = mk(4'h0,1,1,32'h12345678, 4'h0,2'd0,0,1,32'h120,32'hA5A50003, 4'h0,0,32'hDEADBEEF);
    tbl[14] = mk(4'h0,1,0,32'h0,        4'h0,2'd0,0,1,32'h120,32'hA5A50003, 4'h4,1,32'hDEADBEEF);
    tbl[15] = mk(4'h1,1,0,32'h0,        4'h1,2'd0,0,1,32'h120,32'hA5A50003, 4'h0,1,32'hDEADBEEF);
    tbl[16] = mk(4'h0,0,0,32'h0,        4'h0,2'd2,1,1,32'h100,32'hA5A50003, 4'h0,1,32'hDEADBEEF);
    tbl[17] = mk(4'h0,0,0,32'h0,        4'h0,2'd2,1,1,32'h100,32'hA5A50003, 4'h0,1,32'hDEADBEEF);
    tbl[18] = mk(4'h0,0,0,32'h0,        4'h0,2'd2,1,1,32'h100,32'hA5A50003, 4'h0,1,32'hDEADBEEF);
    tbl[19] = mk(4'h0,1,0,32'h0,        4'h0,2'd2,1,1,32'h100,32'hA5A50003, 4'h0,1,32'hDEADBEEF);
    tbl[20] = mk(4'h0,1,0,32'h0,        4'h0,2'd0,0,1,32'h100,32'hA5A50001, 4'h0,1,32'hDEADBEEF);
    tbl[21] = mk(4'h8,1,0,32'h0,        4'h8,2'd0,0,1,32'h100,32'hA5A50001, 4'h1,0,32'hDEADBEEF);
    tbl[22] = mk(4'h0,1,0,32'h0,        4'h0,2'd2,1,0,32'h130,32'hA5A50001, 4'h0,0,32'hDEADBEEF);
    tbl[23] = mk(4'h0,1,0,32'hCAFE0003, 4'h0,2'd0,0,0,32'h130,32'hA5A50001, 4'h0,0,32'hDEADBEEF);
    tbl[24] = mk(4'h0,1,0,32'h0,        4'h0,2'd0,0,0,32'h130,32'hA5A50001, 4'h8,0,32'hCAFE0003);

    // Reset state
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_hsel",   32'(HSEL),   32'd0);
    chk("rst_haddr",  HADDR,       32'd0);
    chk("rst_hwdata", HWDATA,      32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_ack",    32'(ack),    32'd0);
    HRESET = 1'b0;
    chk("hburst", 32'(HBURST), 32'd0);
    chk("hprot",  32'(HPROT),  32'd3);
    chk("hready", 32'(HREADY), 32'(HREADYOUT));

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rq, tbl[i].rdy, tbl[i].resp, tbl[i].rdata);
      chk($sformatf("v%0d_ack", i),    32'(ack),     32'(tbl[i].e_ack));
      chk($sformatf("v%0d_htrans", i), 32'(HTRANS),  32'(tbl[i].e_trans));
      chk($sformatf("v%0d_hsel", i),   32'(HSEL),    32'(tbl[i].e_sel));
      chk($sformatf("v%0d_hwrite", i), 32'(HWRITE),  32'(tbl[i].e_write));
      chk($sformatf("v%0d_haddr", i),  HADDR,        tbl[i].e_addr);
      chk($sformatf("v%0d_hwdata", i), HWDATA,       tbl[i].e_wdata);
      chk($sformatf("v%0d_done", i),   32'(done),    32'(tbl[i].e_done));
      chk($sformatf("v%0d_err", i),    32'(rsp_err), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_rdata", i),  rsp_rdata,    tbl[i].e_rdata);
    end

    // Round robin with all requests held: grants 0,1,2,3,0, one every 3 cycles
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    for (int k = 0; k < 16; k++) begin
      drive((k <= 12) ? 4'hF : 4'h0, 1'b1, 1'b0, 32'h0);
      exp_ack  = ((k % 3) == 0 && k <= 12) ? 4'(1 << order[k / 3]) : 4'h0;
      exp_done = ((k % 3) == 0 && k >= 3)  ? 4'(1 << order[k / 3 - 1]) : 4'h0;
      chk($sformatf("rr%0d_ack", k),  32'(ack),  32'(exp_ack));
      chk($sformatf("rr%0d_done", k), 32'(done), 32'(exp_done));
    end

    // Reset asserted while requester 1 sits in the data phase
    drive(4'h2, 1'b1, 1'b0, 32'h0);
    chk("mr_ack1", 32'(ack), 32'h2);
    drive(4'h0, 1'b1, 1'b0, 32'h0);
    chk("mr_addr", HADDR, 32'h110);
    drive(4'h0, 1'b0, 1'b0, 32'h0);
    #2;
    HRESET = 1'b1;
    #1;
    chk("mr_htrans", 32'(HTRANS), 32'd0);
    chk("mr_hsel",   32'(HSEL),   32'd0);
    chk("mr_done",   32'(done),   32'd0);
    chk("mr_haddr",  HADDR,       32'd0);
    chk("mr_hwdata", HWDATA,      32'd0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    drive(4'hF, 1'b1, 1'b0, 32'h0);
    chk("mr_prio0", 32'(ack), 32'h1);
    drive(4'h0, 1'b1, 1'b0, 32'h0);
    chk("mr_a1_done", 32'(done), 32'h0);
    drive(4'h0, 1'b1, 1'b0, 32'h0);
    chk("mr_a2_done", 32'(done), 32'h0);
    drive(4'h0, 1'b1, 1'b0, 32'h0);
    chk("mr_a3_done", 32'(done), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
